// File: rtl/core_pkg.sv
// Shared core definitions: memory-op encodings, default field widths and the EXE->MEM payload.
package core_pkg;

  localparam int DEF_RADDR_W = 5;
  localparam int DEF_XLEN    = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_MEMOP_W = 4;

  typedef enum logic [DEF_MEMOP_W-1:0] {
    MEM_NOP = 4'h0,
    MEM_LB  = 4'h1,
    MEM_LH  = 4'h2,
    MEM_LW  = 4'h3,
    MEM_LBU = 4'h4,
    MEM_LHU = 4'h5,
    MEM_SB  = 4'h6,
    MEM_SH  = 4'h7,
    MEM_SW  = 4'h8
  } mem_op_e;

  typedef struct packed {
    logic [DEF_RADDR_W-1:0] reg_waddr;
    logic                   reg_we;
    logic [DEF_XLEN-1:0]    reg_wdata;
    logic                   mem_we;
    logic [DEF_ADDR_W-1:0]  mem_addr;
    logic [DEF_XLEN-1:0]    mem_data;
    logic [DEF_MEMOP_W-1:0] mem_op;
  } exe_mem_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-slot valid/ready register (head + skid) with a flopped in_ready and a synchronous clear.
module pipe_skid_buf
  import core_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_e r_state;
  skid_state_e w_state_nxt;
  logic        r_in_ready;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic        w_accept;
  logic        w_drain;
  logic        w_load_head;
  logic        w_head_from_skid;
  logic        w_load_skid;

  assign out_valid_o = (r_state != S_EMPTY);
  assign in_ready_o  = r_in_ready;
  assign out_data_o  = r_head;
  assign w_accept    = in_valid_i & r_in_ready;
  assign w_drain     = out_valid_o & out_ready_i;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt      = r_state;
    w_load_head      = 1'b0;
    w_head_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: if (w_accept) begin
        w_state_nxt = S_ONE;
        w_load_head = 1'b1;
      end
      S_ONE: begin
        if (w_accept && w_drain) begin
          w_load_head = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: if (w_drain) begin
        w_state_nxt      = S_ONE;
        w_head_from_skid = 1'b1;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Flush wins over any accept/drain; stale slot data is harmless once the valids drop.
    if (clr_i) w_state_nxt = S_EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      // NOTE: the two payload slots are reset too, because the head fields are visible at the ports.
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_TWO);
      if (w_load_head)           r_head <= in_data_i;
      else if (w_head_from_skid) r_head <= r_skid;
      if (w_load_skid)           r_skid <= in_data_i;
    end
  end

endmodule

// File: rtl/exe_mem_pipe.sv
// EXE->MEM pipeline register: skid-buffered handshake, flush, qualified controls, stall counter.
module exe_mem_pipe
  import core_pkg::*;
#(
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int XLEN    = DEF_XLEN,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MEMOP_W = DEF_MEMOP_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  input  logic               reg_we_i,
  input  logic [XLEN-1:0]    reg_wdata_i,
  input  logic               mem_we_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [XLEN-1:0]    mem_data_i,
  input  logic [MEMOP_W-1:0] mem_op_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [RADDR_W-1:0] reg_waddr_o,
  output logic               reg_we_o,
  output logic [XLEN-1:0]    reg_wdata_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [XLEN-1:0]    mem_data_o,
  output logic [MEMOP_W-1:0] mem_op_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  localparam int W = RADDR_W + 1 + XLEN + 1 + ADDR_W + XLEN + MEMOP_W;

  logic [W-1:0]       w_in_data;
  logic [W-1:0]       w_out_data;
  logic               w_out_valid;
  logic               w_reg_we;
  logic               w_mem_we;
  logic [MEMOP_W-1:0] w_mem_op;
  logic [CNT_W-1:0]   r_stall_cnt;

  assign w_in_data = {reg_waddr_i, reg_we_i, reg_wdata_i, mem_we_i, mem_addr_i, mem_data_i, mem_op_i};

  pipe_skid_buf #(.W(W)) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (w_in_data),
    .out_valid_o (w_out_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (w_out_data)
  );

  assign {reg_waddr_o, w_reg_we, reg_wdata_o, w_mem_we, mem_addr_o, mem_data_o, w_mem_op} = w_out_data;

  // Control fields must never fire from an invalid head; data fields pass through untouched.
  assign out_valid_o = w_out_valid;
  assign reg_we_o    = w_reg_we & w_out_valid;
  assign mem_we_o    = w_mem_we & w_out_valid;
  assign mem_op_o    = w_out_valid ? w_mem_op : MEMOP_W'(MEM_NOP);
  assign stall_cnt_o = r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule
